// File: rtl/cpu_debug_ocimem_arbiter.sv
// OCI RAM arbiter: shares the single-port debug RAM between the JTAG command path and the Avalon debug_mem slave.
// Optional feature macro: OCIMEM_WRITE_PROTECT_EN (rejects Avalon writes at/above PROT_BASE outside debug mode).
module cpu_debug_ocimem_arbiter #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned RAM_LATENCY = 1,
  parameter int unsigned PROT_BASE   = 32'hE0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              debugack,
  input  logic              jtag_addr_load,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic              jtag_req,
  input  logic              jtag_wr,
  input  logic [DATA_W-1:0] jtag_wdata,
  output logic              jtag_ack,
  output logic [DATA_W-1:0] MonDReg,
  output logic              jtag_overrun,
  input  logic              jtag_clr_status,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              monitor_error
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  state_t            state, state_d;
  logic              owner_jtag, owner_jtag_d;
  logic              last_jtag, last_jtag_d;
  logic              op_wr, op_wr_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ADDR_W-1:0] ptr, ptr_d;
  logic              pend, pend_d;
  logic              pend_wr, pend_wr_d;
  logic [DATA_W-1:0] pend_wdata, pend_wdata_d;
  logic              jtag_ack_d, overrun_d, ram_wren_d;
  logic [DATA_W-1:0] mon_d, av_rdata_d, ram_wdata_d;
  logic [ADDR_W-1:0] ram_addr_d;

  logic av_req_c, grant_jtag_c, grant_av_c, jtag_done_c, prot_block_c;

  assign av_req_c     = av_read | av_write;
  // Last owner loses a tie; debug mode pins priority to JTAG
  assign grant_jtag_c = pend & (debugack | ~av_req_c | ~last_jtag);
  assign grant_av_c   = av_req_c & ~grant_jtag_c;
  assign jtag_done_c  = (state == S_DONE) & owner_jtag;

  assign av_waitrequest = av_req_c & ~((state == S_DONE) & ~owner_jtag);

`ifdef OCIMEM_WRITE_PROTECT_EN
  logic err_set_c;

  assign prot_block_c = ~debugack & (av_address >= ADDR_W'(PROT_BASE));
  assign err_set_c    = (state == S_IDLE) & grant_av_c & av_write & prot_block_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) monitor_error <= 1'b0;
    else          monitor_error <= err_set_c | (monitor_error & ~jtag_clr_status);
  end
`else
  logic unused_prot;

  assign prot_block_c  = 1'b0;
  assign unused_prot   = ^(ADDR_W'(PROT_BASE));
  assign monitor_error = 1'b0;
`endif

  // Access sequencer: owner/address latched on IDLE exit, read data captured at the end of WAIT
  always_comb begin
    state_d      = state;
    owner_jtag_d = owner_jtag;
    last_jtag_d  = last_jtag;
    op_wr_d      = op_wr;
    cnt_d        = cnt;
    ram_addr_d   = ram_addr;
    ram_wdata_d  = ram_wdata;
    ram_wren_d   = 1'b0;
    jtag_ack_d   = 1'b0;
    mon_d        = MonDReg;
    av_rdata_d   = av_readdata;
    unique case (state)
      S_IDLE: begin
        if (grant_jtag_c | grant_av_c) begin
          state_d      = S_ACCESS;
          owner_jtag_d = grant_jtag_c;
          last_jtag_d  = grant_jtag_c;
          op_wr_d      = grant_jtag_c ? pend_wr : av_write;
          ram_addr_d   = grant_jtag_c ? ptr : av_address;
          if (op_wr_d) begin
            ram_wdata_d = grant_jtag_c ? pend_wdata : av_writedata;
            ram_wren_d  = grant_jtag_c | ~prot_block_c;
          end
        end
      end
      S_ACCESS: begin
        if (op_wr) begin
          state_d    = S_DONE;
          jtag_ack_d = owner_jtag;
        end else begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (cnt == CNT_W'(RAM_LATENCY - 1)) begin
          state_d    = S_DONE;
          jtag_ack_d = owner_jtag;
          if (owner_jtag) mon_d      = ram_rdata;
          else            av_rdata_d = ram_rdata;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // JTAG request capture, pointer update and overrun detection
  always_comb begin
    ptr_d        = ptr;
    pend_d       = pend;
    pend_wr_d    = pend_wr;
    pend_wdata_d = pend_wdata;
    overrun_d    = jtag_overrun & ~jtag_clr_status;
    if (jtag_done_c) begin
      pend_d = 1'b0;
      ptr_d  = ptr + 1'b1;
    end else if (jtag_addr_load && !pend) begin
      ptr_d = jtag_addr;
    end
    if (jtag_req) begin
      if (!pend || jtag_done_c) begin
        pend_d       = 1'b1;
        pend_wr_d    = jtag_wr;
        pend_wdata_d = jtag_wdata;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      owner_jtag   <= 1'b0;
      last_jtag    <= 1'b0;
      op_wr        <= 1'b0;
      cnt          <= '0;
      ptr          <= '0;
      pend         <= 1'b0;
      pend_wr      <= 1'b0;
      pend_wdata   <= '0;
      jtag_ack     <= 1'b0;
      jtag_overrun <= 1'b0;
      MonDReg      <= '0;
      av_readdata  <= '0;
      ram_addr     <= '0;
      ram_wren     <= 1'b0;
      ram_wdata    <= '0;
    end else begin
      state        <= state_d;
      owner_jtag   <= owner_jtag_d;
      last_jtag    <= last_jtag_d;
      op_wr        <= op_wr_d;
      cnt          <= cnt_d;
      ptr          <= ptr_d;
      pend         <= pend_d;
      pend_wr      <= pend_wr_d;
      pend_wdata   <= pend_wdata_d;
      jtag_ack     <= jtag_ack_d;
      jtag_overrun <= overrun_d;
      MonDReg      <= mon_d;
      av_readdata  <= av_rdata_d;
      ram_addr     <= ram_addr_d;
      ram_wren     <= ram_wren_d;
      ram_wdata    <= ram_wdata_d;
    end
  end

endmodule

// File: tb/tb_cpu_debug_ocimem_arbiter.sv
// Directed bench for cpu_debug_ocimem_arbiter with a behavioural RAM of read latency LAT.
// Protection checks follow OCIMEM_WRITE_PROTECT_EN.
module tb_cpu_debug_ocimem_arbiter;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          debugack;
  logic          jtag_addr_load;
  logic [AW-1:0] jtag_addr;
  logic          jtag_req;
  logic          jtag_wr;
  logic [DW-1:0] jtag_wdata;
  logic          jtag_ack;
  logic [DW-1:0] MonDReg;
  logic          jtag_overrun;
  logic          jtag_clr_status;
  logic [AW-1:0] av_address;
  logic          av_read;
  logic          av_write;
  logic [DW-1:0] av_writedata;
  logic [DW-1:0] av_readdata;
  logic          av_waitrequest;
  logic [AW-1:0] ram_addr;
  logic          ram_wren;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          monitor_error;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu_debug_ocimem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RAM_LATENCY(LAT), .PROT_BASE(32'hE0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .debugack(debugack),
    .jtag_addr_load(jtag_addr_load), .jtag_addr(jtag_addr),
    .jtag_req(jtag_req), .jtag_wr(jtag_wr), .jtag_wdata(jtag_wdata),
    .jtag_ack(jtag_ack), .MonDReg(MonDReg), .jtag_overrun(jtag_overrun),
    .jtag_clr_status(jtag_clr_status),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_readdata(av_readdata),
    .av_waitrequest(av_waitrequest),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .monitor_error(monitor_error)
  );

  // Behavioural RAM with a bench-side preload port
  logic [DW-1:0] mem     [0:255];
  logic [DW-1:0] rd_pipe [0:LAT-1];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we)        mem[pre_addr] <= pre_data;
    else if (ram_wren) mem[ram_addr] <= ram_wdata;
    rd_pipe[0] <= mem[ram_addr];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = rd_pipe[LAT-1];

  // Completion log: 'J' per jtag_ack, 'A' per Avalon handshake
  logic [7:0] log_q [0:63];
  int         log_n   = 0;
  int         ack_cnt = 0;

  always @(negedge clk) begin
    if (jtag_ack) begin
      log_q[log_n % 64] = "J";
      log_n++;
      ack_cnt++;
    end else if (reset_n && (av_read || av_write) && !av_waitrequest) begin
      log_q[log_n % 64] = "A";
      log_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; debugack = 1'b0; jtag_addr_load = 1'b0; jtag_addr = '0;
    jtag_req = 1'b0; jtag_wr = 1'b0; jtag_wdata = '0; jtag_clr_status = 1'b0;
    av_address = '0; av_read = 1'b0; av_write = 1'b0; av_writedata = '0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic load_ptr(input logic [AW-1:0] a);
    jtag_addr_load = 1'b1; jtag_addr = a;
    tick();
    jtag_addr_load = 1'b0;
  endtask

  // Issue one JTAG request and return cycles from the request to jtag_ack
  task automatic jtag_op(input logic wr, input logic [DW-1:0] d, output int lat);
    jtag_req = 1'b1; jtag_wr = wr; jtag_wdata = d;
    tick();
    jtag_req = 1'b0;
    lat = 1;
    while (!jtag_ack && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // One Avalon transfer; wait_after is waitrequest in the cycle after completion
  task automatic av_xfer(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output logic [DW-1:0] rdata,
                         output int cyc, output logic wait_after);
    av_read = rd; av_write = wr; av_address = a; av_writedata = d;
    #1;
    cyc = 0;
    while (av_waitrequest && cyc < 30) begin
      tick();
      cyc++;
    end
    rdata = av_readdata;
    tick();
    wait_after = av_waitrequest;
    av_read = 1'b0; av_write = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks++; if (jtag_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b expected 0", jtag_ack); end
    checks++; if (MonDReg !== '0) begin errors++; $display("FAIL rst_mondreg: got %h expected 0", MonDReg); end
    checks++; if (jtag_overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b expected 0", jtag_overrun); end
    checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL rst_monerr: got %b expected 0", monitor_error); end
    checks++; if (av_readdata !== '0) begin errors++; $display("FAIL rst_avrd: got %h expected 0", av_readdata); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL rst_wren: got %b expected 0", ram_wren); end
    checks++; if (ram_addr !== '0) begin errors++; $display("FAIL rst_addr: got %h expected 0", ram_addr); end
    checks++; if (ram_wdata !== '0) begin errors++; $display("FAIL rst_wdata: got %h expected 0", ram_wdata); end
    checks++; if (av_waitrequest !== 1'b0) begin errors++; $display("FAIL rst_wait: got %b expected 0", av_waitrequest); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_jtag_burst();
    int lat;
    logic [DW-1:0] wd [0:2];
    wd[0] = 32'hA1; wd[1] = 32'hA2; wd[2] = 32'hA3;
    do_reset();
    poke(8'hFE, '0); poke(8'hFF, '0); poke(8'h00, '0); poke(8'h01, 32'hDEADBEEF);
    load_ptr(8'hFE);
    for (int i = 0; i < 3; i++) begin
      jtag_op(1'b1, wd[i], lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL burst_wr%0d_latency: got %0d expected 3", i, lat); end
    end
    jtag_op(1'b0, '0, lat);
    checks++; if (lat !== 3 + LAT) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", lat, 3 + LAT); end
    checks++; if (MonDReg !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_mondreg: got %h expected deadbeef", MonDReg); end
    tick(); tick();
    checks++; if (mem[8'hFE] !== 32'hA1) begin errors++; $display("FAIL burst_mem_fe: got %h expected a1", mem[8'hFE]); end
    checks++; if (mem[8'hFF] !== 32'hA2) begin errors++; $display("FAIL burst_mem_ff: got %h expected a2", mem[8'hFF]); end
    checks++; if (mem[8'h00] !== 32'hA3) begin errors++; $display("FAIL burst_mem_00: got %h expected a3", mem[8'h00]); end
    checks++; if (jtag_overrun !== 1'b0) begin errors++; $display("FAIL burst_overrun: got %b expected 0", jtag_overrun); end
  endtask

  task automatic test_contention(input logic dbg, input logic [31:0] exp_seq, input int nj);
    int start, cyc, issued, wlow;
    logic [7:0] exp_c;
    do_reset();
    debugack = dbg;
    load_ptr(8'h20);
    start = log_n;
    jtag_req = 1'b1; jtag_wr = 1'b0;
    tick();
    jtag_req = 1'b0;
    av_read = 1'b1; av_address = 8'h30;
    issued = 1; cyc = 0; wlow = 0;
    while ((log_n - start) < 4 && cyc < 200) begin
      tick();
      cyc++;
      jtag_req = 1'b0;
      if (!av_waitrequest) wlow++;
      if (jtag_ack && issued < nj) begin
        jtag_req = 1'b1;
        issued++;
      end
    end
    av_read = 1'b0; jtag_req = 1'b0;
    checks++; if (cyc >= 200) begin errors++; $display("FAIL cont%0b_timeout: got %0d grants expected 4", dbg, log_n - start); end
    for (int i = 0; i < 4; i++) begin
      exp_c = exp_seq[31-8*i -: 8];
      checks++;
      if (log_q[(start + i) % 64] !== exp_c) begin
        errors++;
        $display("FAIL cont%0b_grant%0d: got %c expected %c", dbg, i, log_q[(start + i) % 64], exp_c);
      end
    end
    if (dbg) begin
      checks++; if (wlow !== 0) begin errors++; $display("FAIL cont1_waitrequest: got %0d low cycles expected 0", wlow); end
    end
    for (int i = 0; i < 12; i++) tick();
    checks++; if (log_n - start !== 4) begin errors++; $display("FAIL cont%0b_extra: got %0d accesses expected 4", dbg, log_n - start); end
    checks++; if (jtag_overrun !== 1'b0) begin errors++; $display("FAIL cont%0b_overrun: got %b expected 0", dbg, jtag_overrun); end
    debugack = 1'b0;
  endtask

  task automatic test_overrun();
    int a0;
    do_reset();
    poke(8'h40, '0); poke(8'h41, '0);
    load_ptr(8'h40);
    a0 = ack_cnt;
    jtag_req = 1'b1; jtag_wr = 1'b1; jtag_wdata = 32'h55;
    tick();
    jtag_wdata = 32'h66;
    tick();
    jtag_req = 1'b0;
    checks++; if (jtag_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", jtag_overrun); end
    for (int i = 0; i < 10; i++) tick();
    checks++; if (ack_cnt - a0 !== 1) begin errors++; $display("FAIL ovr_acks: got %0d expected 1", ack_cnt - a0); end
    checks++; if (mem[8'h40] !== 32'h55) begin errors++; $display("FAIL ovr_mem40: got %h expected 55", mem[8'h40]); end
    checks++; if (mem[8'h41] !== 32'h0) begin errors++; $display("FAIL ovr_mem41: got %h expected 0", mem[8'h41]); end
    checks++; if (jtag_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", jtag_overrun); end
    jtag_clr_status = 1'b1;
    tick();
    jtag_clr_status = 1'b0;
    checks++; if (jtag_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", jtag_overrun); end
    jtag_req = 1'b1; jtag_wr = 1'b0;
    tick();
    jtag_clr_status = 1'b1;
    tick();
    jtag_req = 1'b0; jtag_clr_status = 1'b0;
    checks++; if (jtag_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins: got %b expected 1", jtag_overrun); end
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_avalon();
    logic [DW-1:0] rd;
    int cyc;
    logic wa;
    do_reset();
    poke(8'h10, 32'h12345678); poke(8'h11, '0); poke(8'h12, '0);
    av_xfer(1'b1, 1'b0, 8'h10, '0, rd, cyc, wa);
    checks++; if (cyc >= 30) begin errors++; $display("FAIL av_rd_timeout: got %0d cycles expected <30", cyc); end
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL av_rd_data: got %h expected 12345678", rd); end
    checks++; if (wa !== 1'b1) begin errors++; $display("FAIL av_rd_one_cycle: got waitrequest %b expected 1", wa); end
    av_xfer(1'b0, 1'b1, 8'h11, 32'hA5A50011, rd, cyc, wa);
    av_xfer(1'b1, 1'b1, 8'h12, 32'h0000BEEF, rd, cyc, wa);
    tick(); tick();
    checks++; if (mem[8'h11] !== 32'hA5A50011) begin errors++; $display("FAIL av_wr_mem: got %h expected a5a50011", mem[8'h11]); end
    checks++; if (mem[8'h12] !== 32'h0000BEEF) begin errors++; $display("FAIL av_rdwr_is_write: got %h expected 0000beef", mem[8'h12]); end
  endtask

  task automatic test_reset_mid_read();
    int lat, a0;
    do_reset();
    poke(8'h51, 32'hCAFEF00D); poke(8'h52, 32'h11112222);
    load_ptr(8'h51);
    jtag_op(1'b0, '0, lat);
    checks++; if (MonDReg !== 32'hCAFEF00D) begin errors++; $display("FAIL mid_pre_mondreg: got %h expected cafef00d", MonDReg); end
    tick();
    a0 = ack_cnt;
    jtag_req = 1'b1; jtag_wr = 1'b0;
    tick();
    jtag_req = 1'b0;
    tick(); tick();
    reset_n = 1'b0;
    #1;
    checks++; if (MonDReg !== '0) begin errors++; $display("FAIL mid_mondreg: got %h expected 0", MonDReg); end
    checks++; if (ram_addr !== '0) begin errors++; $display("FAIL mid_ram_addr: got %h expected 0", ram_addr); end
    checks++; if (jtag_ack !== 1'b0) begin errors++; $display("FAIL mid_ack: got %b expected 0", jtag_ack); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL mid_wren: got %b expected 0", ram_wren); end
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (ack_cnt - a0 !== 0) begin errors++; $display("FAIL mid_no_ack: got %0d acks expected 0", ack_cnt - a0); end
    checks++; if (MonDReg !== '0) begin errors++; $display("FAIL mid_post_mondreg: got %h expected 0", MonDReg); end
  endtask

  task automatic test_protect();
    logic [DW-1:0] rd;
    int cyc, lat;
    logic wa;
    do_reset();
    poke(8'hF0, 32'h0BAD0000); poke(8'hDF, '0);
    av_xfer(1'b0, 1'b1, 8'hDF, 32'h000000DF, rd, cyc, wa);
    av_xfer(1'b0, 1'b1, 8'hF0, 32'h12345678, rd, cyc, wa);
    checks++; if (cyc >= 30) begin errors++; $display("FAIL prot_handshake: got %0d cycles expected <30", cyc); end
    tick(); tick();
    checks++; if (mem[8'hDF] !== 32'h000000DF) begin errors++; $display("FAIL prot_below_base: got %h expected df", mem[8'hDF]); end
`ifdef OCIMEM_WRITE_PROTECT_EN
    checks++; if (mem[8'hF0] !== 32'h0BAD0000) begin errors++; $display("FAIL prot_mem: got %h expected 0bad0000", mem[8'hF0]); end
    checks++; if (monitor_error !== 1'b1) begin errors++; $display("FAIL prot_monerr: got %b expected 1", monitor_error); end
    load_ptr(8'hF0);
    jtag_op(1'b1, 32'h77, lat);
    tick(); tick();
    checks++; if (mem[8'hF0] !== 32'h77) begin errors++; $display("FAIL prot_jtag_wr: got %h expected 77", mem[8'hF0]); end
    jtag_clr_status = 1'b1;
    tick();
    jtag_clr_status = 1'b0;
    checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL prot_clear: got %b expected 0", monitor_error); end
`else
    checks++; if (mem[8'hF0] !== 32'h12345678) begin errors++; $display("FAIL noprot_mem: got %h expected 12345678", mem[8'hF0]); end
    checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL noprot_monerr: got %b expected 0", monitor_error); end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    test_reset();
    test_jtag_burst();
    test_contention(1'b0, "JAJA", 2);
    test_contention(1'b1, "JJJJ", 4);
    test_overrun();
    test_avalon();
    test_reset_mid_read();
    test_protect();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_debug_ocimem_arbiter.md
Name: cpu_debug_ocimem_arbiter

Overview:
Shares the single-port on-chip debug memory (OCI RAM) between two requesters. One is the JTAG debug path, which issues single-cycle command strobes (take_action_ocimem style) in the clk domain. The other is the CPU-side Avalon-MM debug_mem slave. The block sequences each RAM access, captures read data into MonDReg, auto-increments the JTAG address pointer and reports completion and overrun status to the debug logic.

Parameters:
ADDR_W, 8, OCI RAM word-address width
DATA_W, 32, data width
RAM_LATENCY, 1, RAM read latency in clk cycles (1..3)
PROT_BASE, 8'hE0, first word address of the protected region (used only with the optional feature)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
debugack  in  1  CPU is in debug mode; gives JTAG fixed priority
jtag_addr_load  in  1  pulse: load JTAG pointer from jtag_addr
jtag_addr  in  ADDR_W  JTAG start address
jtag_req  in  1  pulse: one JTAG access request
jtag_wr  in  1  qualifies jtag_req: 1 = write, 0 = read
jtag_wdata  in  DATA_W  JTAG write data, sampled with jtag_req
jtag_ack  out  1  one-cycle pulse when the JTAG access completes
MonDReg  out  DATA_W  last JTAG read data
jtag_overrun  out  1  sticky flag: jtag_req arrived while a JTAG request was pending
jtag_clr_status  in  1  clears jtag_overrun and monitor_error
av_address  in  ADDR_W  Avalon word address
av_read  in  1  Avalon read
av_write  in  1  Avalon write
av_writedata  in  DATA_W  Avalon write data
av_readdata  out  DATA_W  Avalon read data
av_waitrequest  out  1  Avalon waitrequest
ram_addr  out  ADDR_W  RAM address
ram_wren  out  1  RAM write enable
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid RAM_LATENCY cycles after the address
monitor_error  out  1  sticky flag: protected write rejected (optional feature)

Behaviour:
- Reset values: state IDLE; pointer 0; jtag pending flag 0; MonDReg 0; av_readdata 0; jtag_ack 0; jtag_overrun 0; monitor_error 0; ram_wren 0; ram_addr 0; ram_wdata 0.
- JTAG request capture:
  - jtag_req sets the pending flag and latches jtag_wr and jtag_wdata.
  - A jtag_req while pending is dropped and sets jtag_overrun. Pending data is unchanged.
  - jtag_addr_load updates the pointer only while no JTAG access is pending. Otherwise it is ignored.
- State machine:
  - IDLE -> ACCESS when any request is present; the owner is latched on this transition.
  - ACCESS: drive ram_addr and ram_wdata. ram_wren=1 for exactly one cycle on writes. Write -> DONE. Read -> WAIT.
  - WAIT: count RAM_LATENCY-1 further cycles, then capture ram_rdata into MonDReg (JTAG owner) or av_readdata (Avalon owner) -> DONE.
  - DONE: one cycle -> IDLE.
  - Latency from request to completion: write = 3 cycles; read = 3 + RAM_LATENCY cycles.
- Arbitration (evaluated only in IDLE):
  - debugack=1: JTAG always wins.
  - debugack=0: round-robin. The last owner loses a tie. After reset, the first tie goes to JTAG.
- Completion:
  - JTAG owner: in DONE, jtag_ack=1, the pending flag clears and the pointer increments. The pointer wraps from 2^ADDR_W-1 to 0.
  - Avalon owner: av_waitrequest = (av_read|av_write) & ~(DONE & owner==AV). Avalon address and data are sampled in ACCESS. The master must hold them stable until waitrequest deasserts.
- Simultaneous events:
  - A jtag_req in the same cycle as DONE for JTAG is accepted as a new pending request, not an overrun.
  - jtag_clr_status together with a new overrun or error event: the set wins.
  - av_read and av_write both high is treated as a write.
- Reset mid-operation: everything is abandoned, no ack is issued and the pending request is lost.

Optional Feature:
OCIMEM_WRITE_PROTECT_EN
- Defined: an Avalon write with av_address >= PROT_BASE while debugack=0 still completes its handshake through DONE, but ram_wren stays 0 and monitor_error is set. JTAG writes are never blocked.
- Not defined: no protection; monitor_error is tied to 0 and PROT_BASE is unused.

Test Plan:
- JTAG write burst: jtag_addr_load addr=0xFE, then three writes 0xA1, 0xA2, 0xA3 -> RAM words 0xFE, 0xFF, 0x00 written; pointer = 0x01; three jtag_ack pulses, each 3 cycles after its jtag_req.
- JTAG read with RAM_LATENCY=2 at an address holding 0xDEADBEEF -> MonDReg = 0xDEADBEEF, jtag_ack 5 cycles after jtag_req.
- Contention with debugack=0, JTAG and Avalon requests held continuously for 4 accesses -> grants alternate J, A, J, A. Repeat with debugack=1 -> J, J, J, J while Avalon waitrequest stays high.
- Overrun: second jtag_req 1 cycle after the first -> jtag_overrun=1 and only one access occurs; jtag_clr_status -> jtag_overrun=0.
- Avalon read at 0x10 holding 0x12345678 -> waitrequest low for exactly 1 cycle with av_readdata = 0x12345678.
- Reset mid-read: assert reset_n=0 during WAIT -> all outputs at reset values, no ack. With OCIMEM_WRITE_PROTECT_EN, an Avalon write to 0xF0 with debugack=0 -> RAM unchanged and monitor_error=1.
